// File: rtl/token_checker.sv
// token_checker: exit-gate token decode and occupancy check.
// Opens the gate on a hit and locks the exit after repeated misses.
module token_checker #(
  parameter int GATE_CYCLES = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] pattern,
  input  logic [7:0] occupied,
  input  logic       token_valid,
  input  logic [2:0] token,
  output logic       token_ready,
  output logic [2:0] park_number,
  output logic       release_valid,
  output logic       accept,
  output logic       reject,
  output logic       gate_open,
  output logic       locked
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  localparam logic [GW-1:0] GMAX = GW'(GATE_CYCLES);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_CYCLES);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAILS);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    OPEN,
    LOCK
  } state_t;

  state_t        state;
  logic [2:0]    tok_q;
  logic [2:0]    pat_q;
  logic [GW-1:0] gate_cnt;
  logic [LW-1:0] lock_cnt;
  logic [FW-1:0] fail_cnt;

  logic [2:0]    dec;
  logic          hit;
  logic [FW-1:0] fail_nxt;

  assign dec         = tok_q ^ pat_q;
  assign hit         = occupied[dec];
  assign fail_nxt    = fail_cnt + FW'(1);
  assign token_ready = (state == IDLE);

  // Handshake capture, check, gate timing and lockout timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tok_q         <= '0;
      pat_q         <= '0;
      park_number   <= '0;
      release_valid <= 1'b0;
      accept        <= 1'b0;
      reject        <= 1'b0;
      gate_open     <= 1'b0;
      locked        <= 1'b0;
      gate_cnt      <= '0;
      lock_cnt      <= '0;
      fail_cnt      <= '0;
    end else begin
      release_valid <= 1'b0;
      accept        <= 1'b0;
      reject        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (token_valid) begin
            tok_q <= token;
            pat_q <= pattern;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            park_number   <= dec;
            accept        <= 1'b1;
            release_valid <= 1'b1;
            fail_cnt      <= '0;
            gate_open     <= 1'b1;
            gate_cnt      <= GW'(1);
            state         <= OPEN;
          end else begin
            reject <= 1'b1;
            if (fail_nxt == FMAX) begin
              fail_cnt <= '0;
              locked   <= 1'b1;
              lock_cnt <= LW'(1);
              state    <= LOCK;
            end else begin
              fail_cnt <= fail_nxt;
              state    <= IDLE;
            end
          end
        end
        OPEN: begin
          if (gate_cnt == GMAX) begin
            gate_open <= 1'b0;
            gate_cnt  <= '0;
            state     <= IDLE;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
          end
        end
        LOCK: begin
          if (lock_cnt == LMAX) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
            state    <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_token_checker.sv
// tb_token_checker: directed scoreboard bench for token_checker.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_token_checker;

  logic       clk;
  logic       rst;
  logic [2:0] pattern;
  logic [7:0] occupied;
  logic       token_valid;
  logic [2:0] token;
  logic       token_ready;
  logic [2:0] park_number;
  logic       release_valid;
  logic       accept;
  logic       reject;
  logic       gate_open;
  logic       locked;

  token_checker #(
    .GATE_CYCLES(4),
    .MAX_FAILS  (3),
    .LOCK_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pattern      (pattern),
    .occupied     (occupied),
    .token_valid  (token_valid),
    .token        (token),
    .token_ready  (token_ready),
    .park_number  (park_number),
    .release_valid(release_valid),
    .accept       (accept),
    .reject       (reject),
    .gate_open    (gate_open),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       lock;
    logic [2:0] pn;
  } exp_t;

  exp_t       sb[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [2:0] last_pn    = 3'd0;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!token_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/ready_wait"}, 32'(token_ready), 1);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s/scoreboard: observed empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "/accept"}, 32'(accept), 32'(e.hit));
    check({tag, "/release"}, 32'(release_valid), 32'(e.hit));
    check({tag, "/reject"}, 32'(reject), 32'(!e.hit));
    check({tag, "/park"}, 32'(park_number), 32'(e.pn));
    check({tag, "/gate"}, 32'(gate_open), 32'(e.hit));
    check({tag, "/locked"}, 32'(locked), 32'(e.lock));
    check({tag, "/ready"}, 32'(token_ready), 32'(!e.hit && !e.lock));
    if (e.hit) last_pn = e.pn;
  endtask

  task automatic present(input string tag, input logic [2:0] tk,
                         input logic h, input logic l,
                         input logic [2:0] pn, input bit iso);
    exp_t       e;
    logic [2:0] pat_save;
    wait_ready(tag);
    token       = tk;
    token_valid = 1'b1;
    e.hit  = h;
    e.lock = l;
    e.pn   = h ? pn : last_pn;
    sb.push_back(e);
    pat_save = pattern;
    @(posedge clk);
    #1;
    token_valid = 1'b0;
    if (iso) begin
      token   = 3'b000;
      pattern = 3'b000;
    end
    @(negedge clk);
    check({tag, "/check_cycle"},
          32'({token_ready, accept, reject, release_valid}), 0);
    @(negedge clk);
    collect(tag);
    pattern = pat_save;
  endtask

  task automatic gate_window(input string tag);
    int n;
    n = 1;
    @(negedge clk);
    check({tag, "/pulse_once"},
          32'({accept, release_valid, reject}), 0);
    while (gate_open && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "/gate_len"}, n, 4);
    check({tag, "/gate_ready"}, 32'(token_ready), 1);
  endtask

  task automatic lock_window(input string tag, input logic [2:0] tk);
    int n;
    bit bad;
    token       = tk;
    token_valid = 1'b1;
    n   = 1;
    bad = 1'b0;
    @(negedge clk);
    while (locked && n < 100) begin
      if (token_ready || accept || reject) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check({tag, "/lock_len"}, n, 16);
    check({tag, "/lock_held"}, 32'(bad), 0);
    check({tag, "/lock_ready"}, 32'(token_ready), 1);
  endtask

  initial begin
    rst         = 1'b1;
    pattern     = 3'b101;
    occupied    = 8'b0000_0100;
    token_valid = 1'b1;
    token       = 3'b111;
    repeat (3) @(negedge clk);
    check("reset/ready", 32'(token_ready), 1);
    check("reset/park", 32'(park_number), 0);
    check("reset/outs",
          32'({release_valid, accept, reject, gate_open, locked}), 0);
    rst         = 1'b0;
    token_valid = 1'b0;
    @(negedge clk);
    check("reset/no_take", 32'(token_ready), 1);

    present("accept", 3'b111, 1, 0, 3'd2, 0);
    gate_window("accept");

    present("reject", 3'b101, 0, 0, 3'd0, 0);
    @(negedge clk);
    check("reject/once", 32'({reject, gate_open}), 0);

    present("iso", 3'b111, 1, 0, 3'd2, 1);
    gate_window("iso");

    present("lk1_m1", 3'b101, 0, 0, 3'd0, 0);
    present("lk1_m2", 3'b110, 0, 0, 3'd0, 0);
    present("lk1_m3", 3'b000, 0, 1, 3'd0, 0);
    lock_window("lk1", 3'b101);

    present("lk2_m1", 3'b101, 0, 0, 3'd0, 0);
    present("lk2_m2", 3'b101, 0, 0, 3'd0, 0);
    present("lk2_m3", 3'b101, 0, 1, 3'd0, 0);
    lock_window("lk2", 3'b111);

    present("post_lock_hit", 3'b111, 1, 0, 3'd2, 0);
    gate_window("post_lock_hit");

    occupied = 8'b0000_0000;
    present("released", 3'b111, 0, 0, 3'd0, 0);
    occupied = 8'b0000_0100;

    present("fr_hit0", 3'b111, 1, 0, 3'd2, 0);
    gate_window("fr_hit0");
    present("fr_m1", 3'b101, 0, 0, 3'd0, 0);
    present("fr_m2", 3'b101, 0, 0, 3'd0, 0);
    present("fr_hit", 3'b111, 1, 0, 3'd2, 0);
    gate_window("fr_hit");
    present("fr_m3", 3'b101, 0, 0, 3'd0, 0);
    present("fr_m4", 3'b101, 0, 0, 3'd0, 0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_rst/park", 32'(park_number), 0);
    rst = 1'b0;
    last_pn = 3'd0;
    present("rst_m1", 3'b101, 0, 0, 3'd0, 0);
    present("rst_m2", 3'b101, 0, 0, 3'd0, 0);

    present("mid_open", 3'b111, 1, 0, 3'd2, 0);
    @(negedge clk);
    check("mid_open/gate_before", 32'(gate_open), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_open/gate", 32'(gate_open), 0);
    check("mid_open/outs",
          32'({release_valid, accept, reject, locked}), 0);
    check("mid_open/park", 32'(park_number), 0);
    check("mid_open/ready", 32'(token_ready), 1);
    rst = 1'b0;
    last_pn = 3'd0;
    @(negedge clk);
    check("mid_open/after", 32'({gate_open, token_ready}), 1);

    pattern  = 3'b010;
    occupied = 8'b1000_0001;
    present("pat2_hit", 3'b101, 1, 0, 3'd7, 0);
    gate_window("pat2_hit");
    present("pat2_miss", 3'b001, 0, 0, 3'd0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
